dtack_gen: RTL and testbench

DTACK_GEN -- requirements
Module: dtack_gen

---
 rtl/raven_bus_pkg.sv | 63 ++++++
 rtl/dtack_gen_sync2.sv | 38 +++
 rtl/dtack_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_dtack_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raven_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raven_bus_pkg
// Purpose  : Shared definitions for the 68000 bus-cycle controller: the
//            controller state encoding, the address-region enumeration, the
//            A23..A20 decode nibbles and the decode / chip-select helpers.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package raven_bus_pkg;

    // Bus-cycle controller states (explicit 3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_BERR = 3'd3,
        ST_END  = 3'd4
    } state_t;

    // Address regions selected by A23..A20.
    typedef enum logic [1:0] {
        RGN_ROM      = 2'd0,
        RGN_RAM      = 2'd1,
        RGN_IO       = 2'd2,
        RGN_UNMAPPED = 2'd3
    } region_t;

    // Decode nibbles on A23..A20.
    localparam logic [3:0] C_NIB_ROM    = 4'h0;
    localparam logic [3:0] C_NIB_RAM_LO = 4'h1;
    localparam logic [3:0] C_NIB_RAM_HI = 4'h7;
    localparam logic [3:0] C_NIB_IO     = 4'hF;

    // Map the upper address nibble onto a region.
    function automatic region_t decode_region(input logic [3:0] nib);
        region_t r;
        if (nib == C_NIB_ROM) begin
            r = RGN_ROM;
        end else if ((nib >= C_NIB_RAM_LO) && (nib <= C_NIB_RAM_HI)) begin
            r = RGN_RAM;
        end else if (nib == C_NIB_IO) begin
            r = RGN_IO;
        end else begin
            r = RGN_UNMAPPED;
        end
        return r;
    endfunction

    // Active-low chip selects for a region, packed as {rom, ram, io}.
    function automatic logic [2:0] region_cs_n(input region_t r);
        logic [2:0] cs;
        case (r)
            RGN_ROM: cs = 3'b011;
            RGN_RAM: cs = 3'b101;
            RGN_IO:  cs = 3'b110;
            default: cs = 3'b111;
        endcase
        return cs;
    endfunction

endpackage : raven_bus_pkg
`default_nettype wire

// File: rtl/dtack_gen_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for a single asynchronous input. Both
//            stages reset to RESET_VAL so a strobe reads as inactive while
//            reset is asserted.
// Ports    : clk_i   - sampling clock
//            rst_n_i - asynchronous active-low reset
//            d_i     - asynchronous input
//            q_o     - synchronized output (second stage)
// Revision : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/dtack_gen.sv
`default_nettype none
// ============================================================================
// Module   : dtack_gen
// Purpose  : 68000 bus-cycle controller. Synchronizes AS*, decodes A23..A20
//            into ROM / RAM / IO / unmapped, drives the region chip select and
//            generates DTACK* after a per-region number of wait cycles.
//            Every cycle ends with a one-clock END phase in which DTACK*/BERR*
//            are driven high before the tri-state driver is released.
//
//            Build option DTACK_GEN_BERR_TIMEOUT_EN: when defined, unmapped
//            accesses are terminated with BERR* after BERR_CYCLES clocks.
//            When undefined, BERR* is tied high and an unmapped access simply
//            waits in WAIT until the CPU drops AS*.
//
// Params   : ROM_WAIT    - wait cycles before DTACK* for ROM
//            RAM_WAIT    - wait cycles before DTACK* for RAM
//            IO_WAIT     - wait cycles before DTACK* for I/O
//            BERR_CYCLES - unmapped timeout in clocks, 1..255
// Ports    : clk_in   - sole clock (also the CPU clock)
//            reset    - asynchronous active-low reset
//            as_n     - CPU address strobe, async to clk_in
//            addr_hi  - CPU A23..A20
//            dtack_n  - data transfer acknowledge, active low
//            dtack_oe - enable for the dtack_n/berr_n tri-state driver
//            berr_n   - bus error, active low
//            rom_cs_n, ram_cs_n, io_cs_n - region chip selects, active low
// Revision : 1.0  initial release
// ============================================================================
module dtack_gen
    import raven_bus_pkg::*;
#(
    parameter int ROM_WAIT    = 2,
    parameter int RAM_WAIT    = 0,
    parameter int IO_WAIT     = 4,
    parameter int BERR_CYCLES = 64
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       as_n,
    input  logic [3:0] addr_hi,
    output logic       dtack_n,
    output logic       dtack_oe,
    output logic       berr_n,
    output logic       rom_cs_n,
    output logic       ram_cs_n,
    output logic       io_cs_n
);

    localparam logic [7:0] C_ROM_WAIT  = 8'(ROM_WAIT);
    localparam logic [7:0] C_RAM_WAIT  = 8'(RAM_WAIT);
    localparam logic [7:0] C_IO_WAIT   = 8'(IO_WAIT);
    localparam logic [7:0] C_UNMAP_CNT = 8'(BERR_CYCLES - 1);

    // ------------------------------------------------------------------
    // Address strobe synchronizer
    // ------------------------------------------------------------------
    logic as_s;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_as_sync (
        .clk_i   (clk_in),
        .rst_n_i (reset),
        .d_i     (as_n),
        .q_o     (as_s)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t     state_q,  state_d;
    region_t    region_q, region_d;
    logic [7:0] cnt_q,    cnt_d;
    logic       dtack_n_q, dtack_n_d;
    logic       oe_q,      oe_d;
    logic [2:0] cs_n_q,    cs_n_d;     // {rom, ram, io}
    logic       armed_q,   armed_d;
    logic [1:0] vld_q;
`ifdef DTACK_GEN_BERR_TIMEOUT_EN
    logic       berr_n_q,  berr_n_d;
`endif

    region_t    rgn_new;
    logic [7:0] wait_new;
    logic       mapped;
    logic       done_next;

    function automatic logic [7:0] region_wait(input region_t r);
        logic [7:0] w;
        case (r)
            RGN_ROM: w = C_ROM_WAIT;
            RGN_RAM: w = C_RAM_WAIT;
            RGN_IO:  w = C_IO_WAIT;
            default: w = C_UNMAP_CNT;
        endcase
        return w;
    endfunction

    assign rgn_new  = decode_region(addr_hi);
    assign wait_new = region_wait(rgn_new);
    assign mapped   = (region_q != RGN_UNMAPPED);

    // The acknowledge is registered, so it must be requested one cycle
    // before the counter reaches zero for it to appear on the edge where
    // the count expires.
    assign done_next = (cnt_q <= 8'd1);

    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        cnt_d     = (cnt_q == 8'd0) ? 8'd0 : (cnt_q - 8'd1);
        dtack_n_d = 1'b1;
        oe_d      = oe_q;
        cs_n_d    = cs_n_q;
        // The synchronizer holds its reset value for two clocks after
        // reset release; only a high strobe seen after that counts as a
        // genuine end-of-cycle and arms the controller.
        armed_d   = armed_q | (vld_q[1] & as_s);
`ifdef DTACK_GEN_BERR_TIMEOUT_EN
        berr_n_d  = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                oe_d   = 1'b0;
                cs_n_d = 3'b111;
                if (armed_q && !as_s) begin
                    state_d  = ST_WAIT;
                    region_d = rgn_new;
                    cnt_d    = wait_new;
                    oe_d     = 1'b1;
                    cs_n_d   = region_cs_n(rgn_new);
                    // Zero-wait regions acknowledge on the WAIT entry edge.
                    if ((wait_new == 8'd0) && (rgn_new != RGN_UNMAPPED)) begin
                        dtack_n_d = 1'b0;
                    end
`ifdef DTACK_GEN_BERR_TIMEOUT_EN
                    if ((wait_new == 8'd0) && (rgn_new == RGN_UNMAPPED)) begin
                        berr_n_d = 1'b0;
                    end
`endif
                end
            end

            ST_WAIT: begin
                if (as_s) begin
                    // CPU abandoned the cycle before it was terminated.
                    state_d = ST_END;
                    cs_n_d  = 3'b111;
                end else begin
                    if (done_next && mapped) begin
                        dtack_n_d = 1'b0;
                    end
`ifdef DTACK_GEN_BERR_TIMEOUT_EN
                    if (done_next && !mapped) begin
                        berr_n_d = 1'b0;
                    end
`endif
                    if (cnt_q == 8'd0) begin
                        if (mapped) begin
                            state_d = ST_ACK;
                        end
`ifdef DTACK_GEN_BERR_TIMEOUT_EN
                        else begin
                            state_d = ST_BERR;
                        end
`endif
                    end
                end
            end

            ST_ACK: begin
                if (as_s) begin
                    state_d = ST_END;
                    cs_n_d  = 3'b111;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end

`ifdef DTACK_GEN_BERR_TIMEOUT_EN
            ST_BERR: begin
                if (as_s) begin
                    state_d = ST_END;
                    cs_n_d  = 3'b111;
                end else begin
                    berr_n_d = 1'b0;
                end
            end
`endif

            ST_END: begin
                // Strobe activity here is ignored; a new cycle may only
                // start from IDLE, guaranteeing a one-clock gap.
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                cs_n_d  = 3'b111;
            end

            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                cs_n_d  = 3'b111;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            region_q  <= RGN_UNMAPPED;
            cnt_q     <= 8'd0;
            dtack_n_q <= 1'b1;
            oe_q      <= 1'b0;
            cs_n_q    <= 3'b111;
            armed_q   <= 1'b0;
            vld_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            cnt_q     <= cnt_d;
            dtack_n_q <= dtack_n_d;
            oe_q      <= oe_d;
            cs_n_q    <= cs_n_d;
            armed_q   <= armed_d;
            vld_q     <= {vld_q[0], 1'b1};
        end
    end

`ifdef DTACK_GEN_BERR_TIMEOUT_EN
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            berr_n_q <= 1'b1;
        end else begin
            berr_n_q <= berr_n_d;
        end
    end

    assign berr_n = berr_n_q;
`else
    assign berr_n = 1'b1;
`endif

    assign dtack_n  = dtack_n_q;
    assign dtack_oe = oe_q;
    assign rom_cs_n = cs_n_q[2];
    assign ram_cs_n = cs_n_q[1];
    assign io_cs_n  = cs_n_q[0];

endmodule : dtack_gen
`default_nettype wire

// File: tb/tb_dtack_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtack_gen
// Purpose  : Self-checking bench for dtack_gen. Each issued bus cycle pushes
//            its predicted response (chip select, driver-enable length,
//            DTACK*/BERR* start and length) into a queue; a monitor measures
//            every dtack_oe window the DUT produces and compares it with the
//            head of the queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_dtack_gen;

    localparam int ROM_W  = 2;
    localparam int RAM_W  = 0;
    localparam int IO_W   = 4;
    localparam int BERR_C = 64;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b0;
    logic       as_n    = 1'b1;
    logic [3:0] addr_hi = 4'h0;
    logic       dtack_n, dtack_oe, berr_n, rom_cs_n, ram_cs_n, io_cs_n;

    dtack_gen #(
        .ROM_WAIT    (ROM_W),
        .RAM_WAIT    (RAM_W),
        .IO_WAIT     (IO_W),
        .BERR_CYCLES (BERR_C)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .as_n     (as_n),
        .addr_hi  (addr_hi),
        .dtack_n  (dtack_n),
        .dtack_oe (dtack_oe),
        .berr_n   (berr_n),
        .rom_cs_n (rom_cs_n),
        .ram_cs_n (ram_cs_n),
        .io_cs_n  (io_cs_n)
    );

    always #5 clk_in = ~clk_in;

    // Rising-edge index; read at the falling edge it names the last edge.
    int edge_cnt = 0;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [2:0] cs_n;
        int         oe_len;
        int         ack_start;
        int         ack_len;
        int         berr_start;
        int         berr_len;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   prev_h  = -1000;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int region_wait(input logic [3:0] a);
        if (a == 4'h0)       return ROM_W;
        else if (a <= 4'h7)  return RAM_W;
        else if (a == 4'hF)  return IO_W;
        else                 return BERR_C - 1;
    endfunction

    function automatic logic [2:0] region_cs(input logic [3:0] a);
        if (a == 4'h0)       return 3'b011;
        else if (a <= 4'h7)  return 3'b101;
        else if (a == 4'hF)  return 3'b110;
        else                 return 3'b111;
    endfunction

    // One bus cycle: g clocks of strobe high, then d clocks of strobe low.
    // With L the first edge sampling AS* low and H the first edge sampling
    // it high again, the synchronizer adds two clocks, the controller
    // leaves IDLE at max(L+2, previous H+4) and returns to IDLE at H+3.
    task automatic do_txn(input logic [3:0] a, input int d, input int g);
        exp_t e;
        int   l, h, st, w, tlen;
        as_n = 1'b1;
        repeat (g) @(negedge clk_in);
        addr_hi = a;
        as_n    = 1'b0;
        l  = edge_cnt + 1;
        h  = l + d;
        st = l + 2;
        if (prev_h + 4 > st) st = prev_h + 4;
        w    = region_wait(a);
        tlen = h + 2 - st - w;
        if (tlen < 0) tlen = 0;
        e.cs_n       = region_cs(a);
        e.oe_len     = h + 3 - st;
        e.ack_start  = -1;
        e.ack_len    = 0;
        e.berr_start = -1;
        e.berr_len   = 0;
        if (region_cs(a) != 3'b111) begin
            e.ack_len   = tlen;
            e.ack_start = (tlen > 0) ? w : -1;
        end
`ifdef DTACK_GEN_BERR_TIMEOUT_EN
        else begin
            e.berr_len   = tlen;
            e.berr_start = (tlen > 0) ? w : -1;
        end
`endif
        exp_q.push_back(e);
        prev_h = h;
        repeat (d) @(negedge clk_in);
        as_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    bit         in_win = 1'b0;
    int         idx, a_st, a_len, b_st, b_len;
    logic [2:0] cs_first, prev_cs;
    logic       prev_dt, prev_be;
    bit         cs_bad, both_low;
    int         idle_bad = 0;
    exp_t       m;

    always @(negedge clk_in) begin
        if (!reset) begin
            in_win = 1'b0;
        end else if (dtack_oe) begin
            if (!in_win) begin
                in_win   = 1'b1;
                idx      = 0;
                a_st     = -1;  a_len = 0;
                b_st     = -1;  b_len = 0;
                cs_first = {rom_cs_n, ram_cs_n, io_cs_n};
                cs_bad   = 1'b0;
                both_low = 1'b0;
            end else if (prev_cs != cs_first) begin
                cs_bad = 1'b1;   // chip select changed before the last sample
            end
            if (!dtack_n) begin if (a_st < 0) a_st = idx; a_len++; end
            if (!berr_n)  begin if (b_st < 0) b_st = idx; b_len++; end
            if (!dtack_n && !berr_n) both_low = 1'b1;
            prev_cs = {rom_cs_n, ram_cs_n, io_cs_n};
            prev_dt = dtack_n;
            prev_be = berr_n;
            idx++;
        end else begin
            if (in_win) begin
                in_win = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    m = exp_q.pop_front();
                    check("chip_select",    int'(cs_first), int'(m.cs_n));
                    check("oe_length",      idx,   m.oe_len);
                    check("dtack_start",    a_st,  m.ack_start);
                    check("dtack_length",   a_len, m.ack_len);
                    check("berr_start",     b_st,  m.berr_start);
                    check("berr_length",    b_len, m.berr_len);
                    check("cs_stable",      int'(cs_bad), 0);
                    check("end_phase",      int'({prev_cs, prev_dt, prev_be}), 5'b11111);
                    check("dtack_berr_excl", int'(both_low), 0);
                end
            end
            if ({dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n} != 5'b11111) idle_bad++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] a;
        int         d, g;
        bit         seen;

        repeat (3) @(negedge clk_in);
        check("reset_outputs",
              int'({dtack_n, berr_n, dtack_oe, rom_cs_n, ram_cs_n, io_cs_n}), 6'b110111);
        reset = 1'b1;

        // Directed cases.
        do_txn(4'h2, 4, 5);     // RAM, zero wait
        do_txn(4'hF, 8, 3);     // IO, four waits
        do_txn(4'h0, 2, 3);     // ROM aborted during WAIT
        do_txn(4'h0, 3, 3);     // ROM acknowledged on the last possible clock
        do_txn(4'h9, 66, 3);    // unmapped past the timeout
        do_txn(4'hA, 62, 3);    // unmapped released just before the timeout
        do_txn(4'hF, 6, 3);     // back-to-back chain
        do_txn(4'h3, 4, 1);
        do_txn(4'h0, 5, 1);

        // Randomized cycles.
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            g = $urandom_range(1, 4);
            d = (g == 1) ? $urandom_range(3, 10) : $urandom_range(2, 10);
            if ($urandom_range(0, 4) == 0) d = $urandom_range(60, 68);
            do_txn(a, d, g);
        end

        // Reset in the middle of an acknowledged RAM cycle.
        repeat (5) @(negedge clk_in);
        addr_hi = 4'h2;
        as_n    = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_in);
            if (!dtack_n) seen = 1'b1;
        end
        check("pre_reset_dtack_seen", int'(seen), 1);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs",
                 int'({dtack_n, berr_n, dtack_oe, rom_cs_n, ram_cs_n, io_cs_n}), 6'b110111);
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (dtack_oe) seen = 1'b1;
        end
        check("no_cycle_with_strobe_held", int'(seen), 0);
        prev_h = -1000;
        do_txn(4'h5, 4, 5);     // must start once the strobe toggles
        do_txn(4'hF, 7, 2);

        for (int i = 0; i < 300 && (exp_q.size() != 0 || in_win); i++) @(negedge clk_in);
        check("pending_expectations", exp_q.size(), 0);
        check("idle_outputs_clean",   idle_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dtack_gen
`default_nettype wire
